// File: rtl/sine_gen_dds.sv
// Direct-digital-synthesis sine generator: phase accumulator, folded quarter-wave ROM, 2-stage output pipeline.
// Optional +90 degree cosine output is built when SINE_GEN_DDS_COS_EN is defined.
module sine_gen_dds #(
  parameter int PW = 16,
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          phase_clr,
  input  logic [PW-1:0] ftw_in,
  input  logic          ftw_valid,
  output logic          ftw_ready,
  output logic [DW-1:0] sine,
  output logic          sine_valid,
  output logic          wrap
`ifdef SINE_GEN_DDS_COS_EN
  ,
  output logic [DW-1:0] cosine
`endif
);

  localparam int            TN  = 2 ** AW;
  localparam logic [PW-1:0] QTR = PW'(1) << (PW - 2);

  // Elaboration-time sine in Q28 fixed point (Taylor series) so the ROM stays parametrised.
  function automatic longint tab_val(longint i);
    longint x, x2, term, sum, amp;
    x    = (64'sd843314857 * (2 * i + 1)) >>> (AW + 2);
    x2   = (x * x) >>> 28;
    term = x;
    sum  = x;
    for (int k = 1; k <= 9; k++) begin
      term = -((term * x2) >>> 28) / longint'((2 * k) * (2 * k + 1));
      sum += term;
    end
    amp = (64'sd1 <<< (DW - 1)) - 64'sd1;
    return (amp * sum + (64'sd1 <<< 27)) >>> 28;
  endfunction

  // Quadrant fold: odd quadrants read the table backwards.
  function automatic logic [AW-1:0] fold_addr(logic [AW+1:0] top);
    logic [AW-1:0] idx;
    idx = top[AW-1:0];
    return top[AW] ? ~idx : idx;
  endfunction

  logic [DW-2:0] tab [TN];

  for (genvar i = 0; i < TN; i++) begin : g_tab
    localparam longint TV = tab_val(longint'(i));
    assign tab[i] = TV[DW-2:0];
  end

  logic [PW-1:0] acc, ftw_reg, pend_ftw;
  logic          pend;
  logic [PW:0]   sum;
  logic          carry, apply, xfer;

  assign sum       = {1'b0, acc} + {1'b0, ftw_reg};
  assign carry     = enable & sum[PW];
  assign apply     = pend & (phase_clr | ~enable | carry);
  assign xfer      = ftw_valid & ~pend;
  assign ftw_ready = ~pend;

  // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      ftw_reg  <= '0;
      pend_ftw <= '0;
      pend     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      if (phase_clr)   acc <= '0;
      else if (enable) acc <= sum[PW-1:0];
      wrap <= carry & ~phase_clr;
      // apply needs pend set and xfer needs it clear, so they never coincide
      if (apply) begin
        ftw_reg <= pend_ftw;
        pend    <= 1'b0;
      end else if (xfer) begin
        pend_ftw <= ftw_in;
        pend     <= 1'b1;
      end
    end
  end

  logic [DW-2:0] mag;
  logic          sgn, v1;

  // NOTE: the table is a constant ROM and needs no reset; only the pipeline registers are reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mag        <= '0;
      sgn        <= 1'b0;
      v1         <= 1'b0;
      sine       <= '0;
      sine_valid <= 1'b0;
    end else begin
      mag        <= tab[fold_addr(acc[PW-1 -: AW+2])];
      sgn        <= acc[PW-1];
      v1         <= enable;
      sine_valid <= v1;
      if (v1) sine <= sgn ? -{1'b0, mag} : {1'b0, mag};
    end
  end

`ifdef SINE_GEN_DDS_COS_EN
  logic [PW-1:0] acc_c;
  logic [DW-2:0] mag_c;
  logic          sgn_c;

  assign acc_c = acc + QTR;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mag_c  <= '0;
      sgn_c  <= 1'b0;
      cosine <= '0;
    end else begin
      mag_c <= tab[fold_addr(acc_c[PW-1 -: AW+2])];
      sgn_c <= acc_c[PW-1];
      if (v1) cosine <= sgn_c ? -{1'b0, mag_c} : {1'b0, mag_c};
    end
  end
`endif

endmodule
